// File: rtl/instruction_mem_loader.sv
// instruction_mem_loader: boot-time loader that turns a byte stream
// (LEN_LO, LEN_HI, then 4*N little-endian payload bytes) into sequential
// single-cycle writes to instruction memory, holding the CPU until done.
// Optional feature macro: CHECKSUM_EN -- when defined, one trailing XOR
// checksum byte (over the length and payload bytes) must match for DONE.
module instruction_mem_loader #(
    parameter int unsigned MAX_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] imem_addr,
    output logic        imem_wr_en,
    output logic [31:0] imem_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [14:0] words_loaded
);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
`ifdef CHECKSUM_EN
        CSUM   = 3'd4,
`endif
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    // State entered once the payload is complete (or N == 0).
`ifdef CHECKSUM_EN
    localparam state_t TAIL_STATE = CSUM;
`else
    localparam state_t TAIL_STATE = DONE;
`endif
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    // States in which a byte may be taken from the source.
    function automatic logic accepts_bytes(input state_t s);
        logic r;
        case (s)
            LEN_LO, LEN_HI, DATA: r = 1'b1;
`ifdef CHECKSUM_EN
            CSUM:                 r = 1'b1;
`endif
            default:              r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef CHECKSUM_EN
    // Running checksum is a plain byte-wise XOR.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t      state;
    state_t      next_state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_lo;
    logic        accept;
    logic [15:0] len_full;
    logic        more_words;
    logic        last_byte;
`ifdef CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accept     = rx_valid & rx_ready;
    assign len_full   = {rx_data, len[7:0]};
    assign more_words = (({1'b0, words_loaded}) + 16'd1) < len;
    assign last_byte  = (byte_idx == 2'd3);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LEN_LO;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; terminal states hold until reset.
    always_comb begin
        next_state = state;
        case (state)
            LEN_LO: begin
                if (accept) next_state = LEN_HI;
                else        next_state = state;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0)                 next_state = TAIL_STATE;
                    else if ({1'b0, len_full} > MAX_LEN)   next_state = ERROR;
                    else                                   next_state = DATA;
                end else begin
                    next_state = state;
                end
            end
            DATA: begin
                if (accept && last_byte) next_state = WRITE;
                else                     next_state = state;
            end
            WRITE: begin
                if (more_words) next_state = DATA;
                else            next_state = TAIL_STATE;
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum) next_state = DONE;
                    else                 next_state = ERROR;
                end else begin
                    next_state = state;
                end
            end
`endif
            DONE:    next_state = DONE;
            ERROR:   next_state = ERROR;
            default: next_state = ERROR;
        endcase
    end

    // Length capture, byte assembly and word counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len          <= 16'd0;
            byte_idx     <= 2'd0;
            word_lo      <= 24'd0;
            words_loaded <= 15'd0;
        end else begin
            case (state)
                LEN_LO: if (accept) len[7:0] <= rx_data;
                LEN_HI: if (accept) len <= len_full;
                DATA: begin
                    if (accept) begin
                        case (byte_idx)
                            2'd0:    word_lo[7:0]   <= rx_data;
                            2'd1:    word_lo[15:8]  <= rx_data;
                            2'd2:    word_lo[23:16] <= rx_data;
                            default: word_lo        <= word_lo;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                WRITE:   words_loaded <= words_loaded + 15'd1;
                default: len <= len;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    // Checksum accumulates the length bytes and every payload byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (accept && (state == LEN_LO || state == LEN_HI || state == DATA)) begin
            csum <= csum_step(csum, rx_data);
        end
    end
`endif

    // Registered outputs decoded from the state being entered, so each output
    // is valid for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready   <= 1'b0;
            imem_wr_en <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_data  <= 32'd0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            rx_ready   <= accepts_bytes(next_state);
            imem_wr_en <= (next_state == WRITE);
            if (state == DATA && accept && last_byte) begin
                imem_addr <= BASE_ADDR + {15'd0, words_loaded, 2'b00};
                imem_data <= {rx_data, word_lo};
            end
            cpu_hold   <= (next_state != DONE);
            load_done  <= (next_state == DONE);
            load_error <= (next_state == ERROR);
        end
    end

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Self-checking bench for instruction_mem_loader: builds byte streams from a
// list of payload words, derives the expected memory writes and final status
// directly from the stream format, and checks the DUT every cycle.
module tb_instruction_mem_loader;

    localparam int          MAXW = 16384;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] imem_addr;
    logic        imem_wr_en;
    logic [31:0] imem_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [14:0] words_loaded;

    instruction_mem_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_addr(imem_addr), .imem_wr_en(imem_wr_en),
        .imem_data(imem_data), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          widx = 0;
    logic [7:0]  pay_q[$];
    logic [7:0]  stream_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    bit          exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Per-cycle checks against the expected write list and status rules.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                widx = 0;
            end else begin
                chk("words_loaded_track", 32'(words_loaded), 32'(widx));
                if (!load_done) chk("cpu_hold_before_done", 32'(cpu_hold), 32'd1);
                if (load_done) begin
                    chk("done_cpu_hold", 32'(cpu_hold), 32'd0);
                    chk("done_rx_ready", 32'(rx_ready), 32'd0);
                    chk("done_not_error", 32'(load_error), 32'd0);
                end
                if (load_error) begin
                    chk("error_rx_ready", 32'(rx_ready), 32'd0);
                    chk("error_no_write", 32'(imem_wr_en), 32'd0);
                end
                if (imem_wr_en) begin
                    chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
                    if (widx < int'(exp_addr.size())) begin
                        chk("write_addr", imem_addr, exp_addr[widx]);
                        chk("write_data", imem_data, exp_data[widx]);
                    end else begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, want no write",
                                 imem_addr, imem_data);
                    end
                    widx++;
                end
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_data", imem_data, 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_error", 32'(load_error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill_pay(input int n);
        pay_q.delete();
        for (int i = 0; i < 4 * n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference model: stream bytes, expected writes and final outcome.
    task automatic make_stream(input int n, input bit bad_csum);
        logic [7:0] x;
        stream_q.delete();
        exp_addr.delete();
        exp_data.delete();
        stream_q.push_back(n[7:0]);
        stream_q.push_back(n[15:8]);
        x = n[7:0] ^ n[15:8];
        if (n > MAXW) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) begin
                stream_q.push_back(pay_q[4 * k + b]);
                x = x ^ pay_q[4 * k + b];
            end
            exp_addr.push_back(BASE + 32'(4 * k));
            exp_data.push_back({pay_q[4 * k + 3], pay_q[4 * k + 2], pay_q[4 * k + 1], pay_q[4 * k]});
        end
        exp_done = 1'b1;
        exp_err  = 1'b0;
`ifdef CHECKSUM_EN
        stream_q.push_back(bad_csum ? (x ^ 8'h03) : x);
        if (bad_csum) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
        end
`else
        if (bad_csum) x = 8'd0;
`endif
    endtask

    // Offer one byte (after an idle gap) and wait, bounded, for the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 64; t++) begin
            if (rx_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        else    rx_valid = 1'b0;
    endtask

    task automatic run_stream(input int count, input int gapmax);
        int acc;
        bit ok;
        acc = 0;
        for (int i = 0; i < count; i++) begin
            send_byte(stream_q[i], int'($urandom_range(0, gapmax)), ok);
            if (!ok) break;
            acc++;
        end
        rx_valid = 1'b0;
        chk("bytes_accepted", 32'(acc), 32'(count));
    endtask

    task automatic check_end();
        int t;
        t = 0;
        while (!(load_done || load_error) && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("end_done", 32'(load_done), 32'(exp_done));
        chk("end_error", 32'(load_error), 32'(exp_err));
        chk("end_cpu_hold", 32'(cpu_hold), exp_done ? 32'd0 : 32'd1);
        chk("end_words", 32'(words_loaded), 32'(exp_addr.size()));
        chk("end_write_count", 32'(widx), 32'(exp_addr.size()));
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        repeat (4) @(negedge clk);
        chk("terminal_refuses_bytes", 32'(rx_ready), 32'd0);
        chk("terminal_words_stable", 32'(words_loaded), 32'(exp_addr.size()));
        rx_valid = 1'b0;
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none
        repeat (2) @(negedge clk);
        check_reset_vals();
        #2 reset = 1'b0;
        @(negedge clk);

        // Two-word example image.
        pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        make_stream(2, 1'b0);
        chk("model_n_writes", 32'(exp_addr.size()), 32'd2);
        chk("model_addr1", exp_addr[1], 32'h0000_0004);
        chk("model_data0", exp_data[0], 32'h0000_0013);
        chk("model_data1", exp_data[1], 32'h0010_0093);
        run_stream(stream_q.size(), 2);
        check_end();
        chk("example_words_loaded", 32'(words_loaded), 32'd2);
        chk("example_last_addr", imem_addr, 32'h0000_0004);
        do_reset();

        // Empty image.
        pay_q.delete();
        make_stream(0, 1'b0);
        run_stream(stream_q.size(), 1);
`ifndef CHECKSUM_EN
        chk("n0_done_next_cycle", 32'(load_done), 32'd1);
`endif
        check_end();
        do_reset();

        // One past the maximum length.
        make_stream(16385, 1'b0);
        run_stream(2, 1);
        check_end();
        chk("n16385_error", 32'(load_error), 32'd1);
        do_reset();

        // Maximum encodable length, also rejected.
        make_stream(65535, 1'b0);
        run_stream(2, 0);
        check_end();
        do_reset();

        // Back-to-back bytes with rx_valid never dropped.
        fill_pay(1);
        make_stream(1, 1'b0);
        run_stream(stream_q.size(), 0);
        check_end();
        do_reset();

        // Reset after six payload bytes of a three-word image.
        fill_pay(3);
        make_stream(3, 1'b0);
        run_stream(8, 1);
        @(negedge clk);
        chk("midload_words", 32'(words_loaded), 32'd1);
        do_reset();
        fill_pay(1);
        make_stream(1, 1'b0);
        run_stream(stream_q.size(), 2);
        check_end();
        chk("after_abort_addr", imem_addr, BASE);
        do_reset();

`ifdef CHECKSUM_EN
        pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        make_stream(1, 1'b0);
        chk("model_csum", 32'(stream_q[6]), 32'h0000_0001);
        run_stream(stream_q.size(), 1);
        check_end();
        do_reset();
        make_stream(1, 1'b1);
        chk("model_bad_csum", 32'(stream_q[6]), 32'h0000_0002);
        run_stream(stream_q.size(), 1);
        check_end();
        chk("bad_csum_error", 32'(load_error), 32'd1);
        do_reset();
`endif

        // Randomized images and pacing.
        for (int it = 0; it < 8; it++) begin
            n = int'($urandom_range(1, 12));
            fill_pay(n);
            make_stream(n, (it % 3) == 2);
            run_stream(stream_q.size(), int'($urandom_range(0, 3)));
            check_end();
            do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
